// File: rtl/maj_pkg.sv
// Shared constants and count type for the 255-input majority voter family.
package maj_pkg;

    localparam int unsigned N         = 255;
    localparam int unsigned THRESHOLD = 128;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned IDX_W     = 8;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage : maj_pkg

// File: rtl/maj255_voter_if.sv
// Vector-in / count-out bundle between the voter and its population counter.
interface maj255_voter_if;
    import maj_pkg::*;

    logic [N-1:0] vec;
    cnt_t         cnt;

    modport master (output vec, input  cnt);
    modport slave  (input  vec, output cnt);

endinterface : maj255_voter_if

// File: rtl/popcount255.sv
// Combinational 255-bit population counter: 3:2 compressor layers on count-wide
// operands until two remain, then one final carry-propagate add.
module popcount255
    import maj_pkg::*;
(
    maj255_voter_if.slave bus
);

    // 255 -> 170 -> 114 -> ... -> 2 needs 13 layers; extra layers are no-ops.
    localparam int LAYERS = 16;

    always_comb begin : csa_tree
        cnt_t ops [N];
        cnt_t nxt [N];
        cnt_t a, b, c;
        int   n, g, rem;

        a   = '0;
        b   = '0;
        c   = '0;
        g   = 0;
        rem = 0;
        for (int i = 0; i < int'(N); i++) begin
            ops[IDX_W'(i)] = cnt_t'(bus.vec[IDX_W'(i)]);
        end
        n = int'(N);

        for (int l = 0; l < LAYERS; l++) begin
            nxt = ops;
            if (n > 2) begin
                g   = n / 3;
                rem = n - 3 * g;
                for (int i = 0; i < int'(N) / 3; i++) begin
                    if (i < g) begin
                        a = ops[IDX_W'(3 * i)];
                        b = ops[IDX_W'(3 * i + 1)];
                        c = ops[IDX_W'(3 * i + 2)];
                        nxt[IDX_W'(2 * i)]     = a ^ b ^ c;
                        nxt[IDX_W'(2 * i + 1)] = ((a & b) | (a & c) | (b & c)) << 1;
                    end
                end
                // Operands left over from an incomplete triple pass through.
                for (int r = 0; r < 2; r++) begin
                    if (r < rem) begin
                        nxt[IDX_W'(2 * g + r)] = ops[IDX_W'(3 * g + r)];
                    end
                end
                n = 2 * g + rem;
            end
            ops = nxt;
        end

        bus.cnt = ops[0] + ops[1];
    end

endmodule : popcount255

// File: rtl/maj255_voter.sv
// 255-input majority voter: y0 registers (popcount(x) >= 128) every clock.
module maj255_voter
    import maj_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic x0,   x1,   x2,   x3,   x4,   x5,   x6,   x7,   x8,   x9,
    input  logic x10,  x11,  x12,  x13,  x14,  x15,  x16,  x17,  x18,  x19,
    input  logic x20,  x21,  x22,  x23,  x24,  x25,  x26,  x27,  x28,  x29,
    input  logic x30,  x31,  x32,  x33,  x34,  x35,  x36,  x37,  x38,  x39,
    input  logic x40,  x41,  x42,  x43,  x44,  x45,  x46,  x47,  x48,  x49,
    input  logic x50,  x51,  x52,  x53,  x54,  x55,  x56,  x57,  x58,  x59,
    input  logic x60,  x61,  x62,  x63,  x64,  x65,  x66,  x67,  x68,  x69,
    input  logic x70,  x71,  x72,  x73,  x74,  x75,  x76,  x77,  x78,  x79,
    input  logic x80,  x81,  x82,  x83,  x84,  x85,  x86,  x87,  x88,  x89,
    input  logic x90,  x91,  x92,  x93,  x94,  x95,  x96,  x97,  x98,  x99,
    input  logic x100, x101, x102, x103, x104, x105, x106, x107, x108, x109,
    input  logic x110, x111, x112, x113, x114, x115, x116, x117, x118, x119,
    input  logic x120, x121, x122, x123, x124, x125, x126, x127, x128, x129,
    input  logic x130, x131, x132, x133, x134, x135, x136, x137, x138, x139,
    input  logic x140, x141, x142, x143, x144, x145, x146, x147, x148, x149,
    input  logic x150, x151, x152, x153, x154, x155, x156, x157, x158, x159,
    input  logic x160, x161, x162, x163, x164, x165, x166, x167, x168, x169,
    input  logic x170, x171, x172, x173, x174, x175, x176, x177, x178, x179,
    input  logic x180, x181, x182, x183, x184, x185, x186, x187, x188, x189,
    input  logic x190, x191, x192, x193, x194, x195, x196, x197, x198, x199,
    input  logic x200, x201, x202, x203, x204, x205, x206, x207, x208, x209,
    input  logic x210, x211, x212, x213, x214, x215, x216, x217, x218, x219,
    input  logic x220, x221, x222, x223, x224, x225, x226, x227, x228, x229,
    input  logic x230, x231, x232, x233, x234, x235, x236, x237, x238, x239,
    input  logic x240, x241, x242, x243, x244, x245, x246, x247, x248, x249,
    input  logic x250, x251, x252, x253, x254,
    output logic y0
);

    maj255_voter_if pc_bus ();

    logic maj_c;
    logic y0_d;
    logic y0_q;

    // x0 lands in bit 0 of the packed vector.
    assign pc_bus.vec = {
        x254, x253, x252, x251, x250, x249, x248, x247, x246, x245,
        x244, x243, x242, x241, x240, x239, x238, x237, x236, x235,
        x234, x233, x232, x231, x230, x229, x228, x227, x226, x225,
        x224, x223, x222, x221, x220, x219, x218, x217, x216, x215,
        x214, x213, x212, x211, x210, x209, x208, x207, x206, x205,
        x204, x203, x202, x201, x200, x199, x198, x197, x196, x195,
        x194, x193, x192, x191, x190, x189, x188, x187, x186, x185,
        x184, x183, x182, x181, x180, x179, x178, x177, x176, x175,
        x174, x173, x172, x171, x170, x169, x168, x167, x166, x165,
        x164, x163, x162, x161, x160, x159, x158, x157, x156, x155,
        x154, x153, x152, x151, x150, x149, x148, x147, x146, x145,
        x144, x143, x142, x141, x140, x139, x138, x137, x136, x135,
        x134, x133, x132, x131, x130, x129, x128, x127, x126, x125,
        x124, x123, x122, x121, x120, x119, x118, x117, x116, x115,
        x114, x113, x112, x111, x110, x109, x108, x107, x106, x105,
        x104, x103, x102, x101, x100, x99,  x98,  x97,  x96,  x95,
        x94,  x93,  x92,  x91,  x90,  x89,  x88,  x87,  x86,  x85,
        x84,  x83,  x82,  x81,  x80,  x79,  x78,  x77,  x76,  x75,
        x74,  x73,  x72,  x71,  x70,  x69,  x68,  x67,  x66,  x65,
        x64,  x63,  x62,  x61,  x60,  x59,  x58,  x57,  x56,  x55,
        x54,  x53,  x52,  x51,  x50,  x49,  x48,  x47,  x46,  x45,
        x44,  x43,  x42,  x41,  x40,  x39,  x38,  x37,  x36,  x35,
        x34,  x33,  x32,  x31,  x30,  x29,  x28,  x27,  x26,  x25,
        x24,  x23,  x22,  x21,  x20,  x19,  x18,  x17,  x16,  x15,
        x14,  x13,  x12,  x11,  x10,  x9,   x8,   x7,   x6,   x5,
        x4,   x3,   x2,   x1,   x0
    };

    popcount255 u_popcount (
        .bus (pc_bus.slave)
    );

    assign maj_c = (pc_bus.cnt >= cnt_t'(THRESHOLD));
    assign y0_d  = maj_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y0_q <= 1'b0;
        end else begin
            y0_q <= y0_d;
        end
    end

    assign y0 = y0_q;

endmodule : maj255_voter

// File: tb/tb_maj255_voter.sv
// Directed and random checks of the registered 255-input majority voter.
module tb_maj255_voter;
    import maj_pkg::*;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] xv;
    logic         y0;
    int           checks;
    int           failures;

    maj255_voter_if tb_bus ();
    assign tb_bus.vec = xv;
    assign tb_bus.cnt = cnt_t'($countones(xv));

    maj255_voter dut (
        .clk(clk), .rst_n(rst_n), .y0(y0),
        .x0(xv[0]), .x1(xv[1]), .x2(xv[2]), .x3(xv[3]), .x4(xv[4]), .x5(xv[5]), .x6(xv[6]), .x7(xv[7]), .x8(xv[8]), .x9(xv[9]),
        .x10(xv[10]), .x11(xv[11]), .x12(xv[12]), .x13(xv[13]), .x14(xv[14]), .x15(xv[15]), .x16(xv[16]), .x17(xv[17]), .x18(xv[18]), .x19(xv[19]),
        .x20(xv[20]), .x21(xv[21]), .x22(xv[22]), .x23(xv[23]), .x24(xv[24]), .x25(xv[25]), .x26(xv[26]), .x27(xv[27]), .x28(xv[28]), .x29(xv[29]),
        .x30(xv[30]), .x31(xv[31]), .x32(xv[32]), .x33(xv[33]), .x34(xv[34]), .x35(xv[35]), .x36(xv[36]), .x37(xv[37]), .x38(xv[38]), .x39(xv[39]),
        .x40(xv[40]), .x41(xv[41]), .x42(xv[42]), .x43(xv[43]), .x44(xv[44]), .x45(xv[45]), .x46(xv[46]), .x47(xv[47]), .x48(xv[48]), .x49(xv[49]),
        .x50(xv[50]), .x51(xv[51]), .x52(xv[52]), .x53(xv[53]), .x54(xv[54]), .x55(xv[55]), .x56(xv[56]), .x57(xv[57]), .x58(xv[58]), .x59(xv[59]),
        .x60(xv[60]), .x61(xv[61]), .x62(xv[62]), .x63(xv[63]), .x64(xv[64]), .x65(xv[65]), .x66(xv[66]), .x67(xv[67]), .x68(xv[68]), .x69(xv[69]),
        .x70(xv[70]), .x71(xv[71]), .x72(xv[72]), .x73(xv[73]), .x74(xv[74]), .x75(xv[75]), .x76(xv[76]), .x77(xv[77]), .x78(xv[78]), .x79(xv[79]),
        .x80(xv[80]), .x81(xv[81]), .x82(xv[82]), .x83(xv[83]), .x84(xv[84]), .x85(xv[85]), .x86(xv[86]), .x87(xv[87]), .x88(xv[88]), .x89(xv[89]),
        .x90(xv[90]), .x91(xv[91]), .x92(xv[92]), .x93(xv[93]), .x94(xv[94]), .x95(xv[95]), .x96(xv[96]), .x97(xv[97]), .x98(xv[98]), .x99(xv[99]),
        .x100(xv[100]), .x101(xv[101]), .x102(xv[102]), .x103(xv[103]), .x104(xv[104]), .x105(xv[105]), .x106(xv[106]), .x107(xv[107]), .x108(xv[108]), .x109(xv[109]),
        .x110(xv[110]), .x111(xv[111]), .x112(xv[112]), .x113(xv[113]), .x114(xv[114]), .x115(xv[115]), .x116(xv[116]), .x117(xv[117]), .x118(xv[118]), .x119(xv[119]),
        .x120(xv[120]), .x121(xv[121]), .x122(xv[122]), .x123(xv[123]), .x124(xv[124]), .x125(xv[125]), .x126(xv[126]), .x127(xv[127]), .x128(xv[128]), .x129(xv[129]),
        .x130(xv[130]), .x131(xv[131]), .x132(xv[132]), .x133(xv[133]), .x134(xv[134]), .x135(xv[135]), .x136(xv[136]), .x137(xv[137]), .x138(xv[138]), .x139(xv[139]),
        .x140(xv[140]), .x141(xv[141]), .x142(xv[142]), .x143(xv[143]), .x144(xv[144]), .x145(xv[145]), .x146(xv[146]), .x147(xv[147]), .x148(xv[148]), .x149(xv[149]),
        .x150(xv[150]), .x151(xv[151]), .x152(xv[152]), .x153(xv[153]), .x154(xv[154]), .x155(xv[155]), .x156(xv[156]), .x157(xv[157]), .x158(xv[158]), .x159(xv[159]),
        .x160(xv[160]), .x161(xv[161]), .x162(xv[162]), .x163(xv[163]), .x164(xv[164]), .x165(xv[165]), .x166(xv[166]), .x167(xv[167]), .x168(xv[168]), .x169(xv[169]),
        .x170(xv[170]), .x171(xv[171]), .x172(xv[172]), .x173(xv[173]), .x174(xv[174]), .x175(xv[175]), .x176(xv[176]), .x177(xv[177]), .x178(xv[178]), .x179(xv[179]),
        .x180(xv[180]), .x181(xv[181]), .x182(xv[182]), .x183(xv[183]), .x184(xv[184]), .x185(xv[185]), .x186(xv[186]), .x187(xv[187]), .x188(xv[188]), .x189(xv[189]),
        .x190(xv[190]), .x191(xv[191]), .x192(xv[192]), .x193(xv[193]), .x194(xv[194]), .x195(xv[195]), .x196(xv[196]), .x197(xv[197]), .x198(xv[198]), .x199(xv[199]),
        .x200(xv[200]), .x201(xv[201]), .x202(xv[202]), .x203(xv[203]), .x204(xv[204]), .x205(xv[205]), .x206(xv[206]), .x207(xv[207]), .x208(xv[208]), .x209(xv[209]),
        .x210(xv[210]), .x211(xv[211]), .x212(xv[212]), .x213(xv[213]), .x214(xv[214]), .x215(xv[215]), .x216(xv[216]), .x217(xv[217]), .x218(xv[218]), .x219(xv[219]),
        .x220(xv[220]), .x221(xv[221]), .x222(xv[222]), .x223(xv[223]), .x224(xv[224]), .x225(xv[225]), .x226(xv[226]), .x227(xv[227]), .x228(xv[228]), .x229(xv[229]),
        .x230(xv[230]), .x231(xv[231]), .x232(xv[232]), .x233(xv[233]), .x234(xv[234]), .x235(xv[235]), .x236(xv[236]), .x237(xv[237]), .x238(xv[238]), .x239(xv[239]),
        .x240(xv[240]), .x241(xv[241]), .x242(xv[242]), .x243(xv[243]), .x244(xv[244]), .x245(xv[245]), .x246(xv[246]), .x247(xv[247]), .x248(xv[248]), .x249(xv[249]),
        .x250(xv[250]), .x251(xv[251]), .x252(xv[252]), .x253(xv[253]), .x254(xv[254])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Apply a vector away from the active edge, then sample just after it.
    task automatic step(input logic [N-1:0] v);
        @(negedge clk);
        xv = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        xv    = '1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (y0 !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cycle %0d: y0=%b expected 0", i, y0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (y0 !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: y0=%b expected 1", y0);
        end
    endtask

    task automatic test_extremes();
        step('0);
        checks++;
        if (y0 !== 1'b0) begin
            failures++;
            $display("FAIL all_zeros: y0=%b expected 0", y0);
        end
        step('1);
        checks++;
        if (y0 !== 1'b1) begin
            failures++;
            $display("FAIL all_ones: y0=%b expected 1", y0);
        end
    endtask

    task automatic test_threshold();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < 127; i++) v[i] = 1'b1;
        step(v);
        checks++;
        if (y0 !== 1'b0) begin
            failures++;
            $display("FAIL thresh_127: y0=%b expected 0", y0);
        end
        v[127] = 1'b1;
        step(v);
        checks++;
        if (y0 !== 1'b1) begin
            failures++;
            $display("FAIL thresh_128: y0=%b expected 1", y0);
        end
        v[0] = 1'b0;
        step(v);
        checks++;
        if (y0 !== 1'b0) begin
            failures++;
            $display("FAIL thresh_back_127: y0=%b expected 0", y0);
        end
    endtask

    task automatic test_position();
        logic [N-1:0] v;
        v = '0;
        for (int i = 127; i < 255; i++) v[i] = 1'b1;
        step(v);
        checks++;
        if (y0 !== 1'b1) begin
            failures++;
            $display("FAIL top_half_128: y0=%b expected 1", y0);
        end
        v[254] = 1'b0;
        step(v);
        checks++;
        if (y0 !== 1'b0) begin
            failures++;
            $display("FAIL top_half_127: y0=%b expected 0", y0);
        end
        // Even indices 2..254 (127 ones) plus x1 gives exactly 128.
        v = '0;
        for (int i = 2; i < 255; i += 2) v[i] = 1'b1;
        v[1] = 1'b1;
        step(v);
        checks++;
        if (y0 !== 1'b1) begin
            failures++;
            $display("FAIL interleave_128: y0=%b expected 1", y0);
        end
        v[1] = 1'b0;
        step(v);
        checks++;
        if (y0 !== 1'b0) begin
            failures++;
            $display("FAIL interleave_127: y0=%b expected 0", y0);
        end
    endtask

    task automatic test_async_reset();
        step('1);
        checks++;
        if (y0 !== 1'b1) begin
            failures++;
            $display("FAIL async_pre: y0=%b expected 1", y0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (y0 !== 1'b0) begin
            failures++;
            $display("FAIL async_drop: y0=%b expected 0", y0);
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (y0 !== 1'b1) begin
            failures++;
            $display("FAIL async_recover: y0=%b expected 1", y0);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        logic         exp;
        int           p;
        for (int k = 0; k < 10000; k++) begin
            p = int'($urandom_range(60, 40));
            for (int b = 0; b < int'(N); b++) begin
                v[b] = (int'($urandom_range(99, 0)) < p);
            end
            step(v);
            exp = ($countones(v) >= 128);
            checks++;
            if (y0 !== exp) begin
                failures++;
                if (failures < 20) begin
                    $display("FAIL random vec %0d cnt=%0d: y0=%b expected %b",
                             k, tb_bus.cnt, y0, exp);
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        xv       = '0;
        test_reset();
        test_extremes();
        test_threshold();
        test_position();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_maj255_voter
